// File: rtl/pc_fetch_unit.sv
// Program-counter / instruction-fetch stage: sequential advance, stall hold,
// branch/jump redirect with wrong-path flush, and halt/resume. All outputs registered.
module pc_fetch_unit #(
    parameter int              WL       = 32,
    parameter logic [WL-1:0]   RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [WL-1:0] br_target,
    input  logic          jmp,
    input  logic [WL-1:0] jmp_target,
    input  logic          halt_req,
    input  logic          resume,
    output logic [WL-1:0] pc_out,
    output logic [WL-1:0] pc_plus,
    output logic          valid_out,
    output logic          flush_out,
    output logic          misalign,
    output logic [WL-1:0] fetch_count
);

    localparam logic [WL-1:0] STEP = WL'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t        state, state_d;
    logic [WL-1:0] pc_d, cnt_d;
    logic          valid_d, flush_d, mis_d;
    // Set when the held pc was already accepted, so resume must step past it.
    logic          adv, adv_d;

    logic          redir;
    logic [WL-1:0] tgt, tgt_al;

    assign redir  = jmp | br_taken;
    assign tgt    = jmp ? jmp_target : br_target;
    assign tgt_al = {tgt[WL-1:2], 2'b00};

    always_comb begin
        state_d = state;
        pc_d    = pc_out;
        valid_d = valid_out;
        flush_d = 1'b0;
        mis_d   = misalign;
        cnt_d   = fetch_count;
        adv_d   = adv;

        unique case (state)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN: begin
                if (redir) begin
                    pc_d    = tgt_al;
                    flush_d = 1'b1;
                    cnt_d   = fetch_count + 1'b1;
                    adv_d   = 1'b0;
                    if (tgt[1:0] != 2'b00)
                        mis_d = 1'b1;
                end else if (!stall) begin
                    cnt_d = fetch_count + 1'b1;
                    adv_d = 1'b1;
                    if (!halt_req)
                        pc_d = pc_out + STEP;
                end else begin
                    adv_d = 1'b0;
                end

                if (halt_req) begin
                    state_d = HALTED;
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            HALTED: begin
                if (redir) begin
                    pc_d  = tgt_al;
                    adv_d = 1'b0;
                    if (tgt[1:0] != 2'b00)
                        mis_d = 1'b1;
                end
                if (resume) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    if (!redir && adv)
                        pc_d = pc_out + STEP;
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= BOOT;
            pc_out      <= RESET_PC;
            pc_plus     <= RESET_PC + STEP;
            valid_out   <= 1'b0;
            flush_out   <= 1'b0;
            misalign    <= 1'b0;
            fetch_count <= '0;
            adv         <= 1'b0;
        end else begin
            state       <= state_d;
            pc_out      <= pc_d;
            pc_plus     <= pc_d + STEP;
            valid_out   <= valid_d;
            flush_out   <= flush_d;
            misalign    <= mis_d;
            fetch_count <= cnt_d;
            adv         <= adv_d;
        end
    end

endmodule
